// File: rtl/function_plotter_pkg.sv
// Shared token, operator and error definitions for the expression front end,
// rpn_encoder and stack_machine.
package function_plotter_pkg;

  localparam int OPERATOR_WIDTH = 3;

  localparam logic [2:0] TOK_NUM    = 3'd0;
  localparam logic [2:0] TOK_VAR_X  = 3'd1;
  localparam logic [2:0] TOK_OP     = 3'd2;
  localparam logic [2:0] TOK_LPAREN = 3'd3;
  localparam logic [2:0] TOK_RPAREN = 3'd4;
  localparam logic [2:0] TOK_END    = 3'd5;

  localparam logic [OPERATOR_WIDTH-1:0] OP_ADD    = 3'd0;
  localparam logic [OPERATOR_WIDTH-1:0] OP_SUB    = 3'd1;
  localparam logic [OPERATOR_WIDTH-1:0] OP_MUL    = 3'd2;
  localparam logic [OPERATOR_WIDTH-1:0] OP_DIV    = 3'd3;
  localparam logic [OPERATOR_WIDTH-1:0] OP_POW    = 3'd4;
  localparam logic [OPERATOR_WIDTH-1:0] OP_PUSH_X = 3'd7;

  localparam logic [1:0] ERR_BAD_TOKEN  = 2'd0;
  localparam logic [1:0] ERR_QUEUE_OVF  = 2'd1;
  localparam logic [1:0] ERR_STACK_OVF  = 2'd2;
  localparam logic [1:0] ERR_PAREN      = 2'd3;

  // Op stack entry: bit 3 marks an open parenthesis, bits [2:0] hold the op code.
  localparam logic [3:0] STACK_LPAREN = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_POP_OPS, S_POP_PAREN, S_FLUSH, S_DONE, S_ERROR
  } enc_state_t;

  function automatic logic [1:0] prec(input logic [OPERATOR_WIDTH-1:0] op);
    case (op)
      OP_ADD, OP_SUB: prec = 2'd1;
      OP_MUL, OP_DIV: prec = 2'd2;
      OP_POW:         prec = 2'd3;
      default:        prec = 2'd0;
    endcase
  endfunction

  function automatic logic right_assoc(input logic [OPERATOR_WIDTH-1:0] op);
    right_assoc = (op == OP_POW);
  endfunction

endpackage

// File: rtl/rpn_encoder_op_stack.sv
// LIFO of 4-bit operator/paren entries; top is combinational from the storage.
module op_stack
  import function_plotter_pkg::*;
#(
  parameter int OP_STACK_SIZE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] push_data,
  output logic [3:0] top,
  output logic       empty,
  output logic       full
);

  localparam int PW = $clog2(OP_STACK_SIZE);
  localparam logic [PW:0] ONE = 1;
  localparam logic [PW:0] DEPTH = OP_STACK_SIZE;

  logic [3:0]  mem [OP_STACK_SIZE];
  logic [PW:0] count;
  logic [PW:0] top_idx;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign top_idx = count - ONE;
  assign top     = empty ? 4'd0 : mem[top_idx[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + ONE;
    end else if (pop && !empty) begin
      count <= count - ONE;
    end
  end

  // Storage needs no reset: entries above count are never read.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem[count[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rpn_encoder.sv
// Shunting-yard infix-to-RPN encoder: accepts tokens, writes one RPN queue entry
// per cycle and reports the final queue length.
module rpn_encoder
  import function_plotter_pkg::*;
#(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int NUMBER_WIDTH          = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  parameter int OUTPUT_VALUE_WIDTH    = NUMBER_WIDTH + 1,
  parameter int OUTPUT_QUEUE_SIZE     = 64,
  parameter int OP_STACK_SIZE         = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 tok_valid,
  output logic                                 tok_ready,
  input  logic [2:0]                           tok_kind,
  input  logic [NUMBER_WIDTH-1:0]              tok_value,
  output logic                                 q_wr_en,
  output logic [$clog2(OUTPUT_QUEUE_SIZE)-1:0] q_wr_addr,
  output logic [OUTPUT_VALUE_WIDTH-1:0]        q_wr_data,
  output logic [$clog2(OUTPUT_QUEUE_SIZE):0]   output_queue_p,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic [1:0]                           err_code
);

  localparam int AW = $clog2(OUTPUT_QUEUE_SIZE);
  localparam logic [AW:0] QUEUE_FULL = OUTPUT_QUEUE_SIZE;
  localparam logic [AW:0] ONE = 1;

  enc_state_t state, state_next;
  logic [2:0] pending, pending_next;
  logic       st_push, st_pop, st_clear, st_empty, st_full;
  logic [3:0] st_push_data, st_top;
  logic       wr, err_set;
  logic [1:0] err_val;
  logic [OUTPUT_VALUE_WIDTH-1:0] wr_data;
  logic       tok_fire;

  op_stack #(.OP_STACK_SIZE(OP_STACK_SIZE)) u_op_stack (
    .clk(clk), .rst_n(rst_n), .clear(st_clear), .push(st_push), .pop(st_pop),
    .push_data(st_push_data), .top(st_top), .empty(st_empty), .full(st_full)
  );

  function automatic logic [OUTPUT_VALUE_WIDTH-1:0] op_word(input logic [2:0] code);
    op_word = '0;
    op_word[OUTPUT_VALUE_WIDTH-1] = 1'b1;
    op_word[2:0] = code;
  endfunction

  // True when the stacked operator must be output before incoming operator o.
  function automatic logic must_pop(input logic [3:0] top, input logic empty,
                                    input logic [2:0] o);
    must_pop = !empty && !top[3] &&
               ((prec(top[2:0]) > prec(o)) ||
                ((prec(top[2:0]) == prec(o)) && !right_assoc(o)));
  endfunction

  assign tok_fire = tok_valid && tok_ready;

  always_comb begin
    state_next   = state;
    pending_next = pending;
    st_push      = 1'b0;
    st_pop       = 1'b0;
    st_clear     = 1'b0;
    st_push_data = 4'd0;
    wr           = 1'b0;
    wr_data      = '0;
    err_set      = 1'b0;
    err_val      = ERR_BAD_TOKEN;
    if (start) begin
      state_next = S_ACCEPT;
      st_clear   = 1'b1;
    end else begin
      case (state)
        S_ACCEPT: if (tok_fire) begin
          case (tok_kind)
            TOK_NUM: begin
              wr = 1'b1;
              wr_data = OUTPUT_VALUE_WIDTH'(tok_value);
            end
            TOK_VAR_X: begin
              wr = 1'b1;
              wr_data = op_word(OP_PUSH_X);
            end
            TOK_OP: begin
              if (tok_value[2:0] > OP_POW) begin
                err_set = 1'b1;
                err_val = ERR_BAD_TOKEN;
              end else if (must_pop(st_top, st_empty, tok_value[2:0])) begin
                pending_next = tok_value[2:0];
                state_next   = S_POP_OPS;
              end else if (st_full) begin
                err_set = 1'b1;
                err_val = ERR_STACK_OVF;
              end else begin
                st_push = 1'b1;
                st_push_data = {1'b0, tok_value[2:0]};
              end
            end
            TOK_LPAREN: begin
              if (st_full) begin
                err_set = 1'b1;
                err_val = ERR_STACK_OVF;
              end else begin
                st_push = 1'b1;
                st_push_data = STACK_LPAREN;
              end
            end
            TOK_RPAREN: state_next = S_POP_PAREN;
            TOK_END:    state_next = S_FLUSH;
            default: begin
              err_set = 1'b1;
              err_val = ERR_BAD_TOKEN;
            end
          endcase
        end
        S_POP_OPS: begin
          if (must_pop(st_top, st_empty, pending)) begin
            st_pop  = 1'b1;
            wr      = 1'b1;
            wr_data = op_word(st_top[2:0]);
          end else if (st_full) begin
            err_set = 1'b1;
            err_val = ERR_STACK_OVF;
          end else begin
            st_push      = 1'b1;
            st_push_data = {1'b0, pending};
            state_next   = S_ACCEPT;
          end
        end
        S_POP_PAREN: begin
          if (st_empty) begin
            err_set = 1'b1;
            err_val = ERR_PAREN;
          end else if (st_top[3]) begin
            st_pop     = 1'b1;
            state_next = S_ACCEPT;
          end else begin
            st_pop  = 1'b1;
            wr      = 1'b1;
            wr_data = op_word(st_top[2:0]);
          end
        end
        S_FLUSH: begin
          if (st_empty) begin
            state_next = S_DONE;
          end else if (st_top[3]) begin
            err_set = 1'b1;
            err_val = ERR_PAREN;
          end else begin
            st_pop  = 1'b1;
            wr      = 1'b1;
            wr_data = op_word(st_top[2:0]);
          end
        end
        default: ;
      endcase
      // A full queue cancels the write and anything that came with it.
      if (wr && (output_queue_p == QUEUE_FULL)) begin
        wr      = 1'b0;
        st_pop  = 1'b0;
        st_push = 1'b0;
        err_set = 1'b1;
        err_val = ERR_QUEUE_OVF;
      end
      if (err_set) state_next = S_ERROR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pending        <= 3'd0;
      tok_ready      <= 1'b0;
      q_wr_en        <= 1'b0;
      q_wr_addr      <= '0;
      q_wr_data      <= '0;
      output_queue_p <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= 2'd0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      q_wr_en   <= wr;
      tok_ready <= (state_next == S_ACCEPT);
      busy      <= (state_next == S_ACCEPT) || (state_next == S_POP_OPS) ||
                   (state_next == S_POP_PAREN) || (state_next == S_FLUSH);
      done      <= (state_next == S_DONE);
      error     <= (state_next == S_ERROR);
      if (st_clear) begin
        output_queue_p <= '0;
        err_code       <= 2'd0;
      end else begin
        if (wr) begin
          q_wr_addr      <= output_queue_p[AW-1:0];
          q_wr_data      <= wr_data;
          output_queue_p <= output_queue_p + ONE;
        end
        if (err_set) err_code <= err_val;
      end
    end
  end

endmodule

// File: tb/tb_rpn_encoder.sv
// Directed bench for rpn_encoder: table of expressions with hand-computed RPN
// queues, plus stack/queue overflow and mid-flush reset sequences.
module tb_rpn_encoder;

  localparam logic [2:0] K_NUM = 3'd0, K_X = 3'd1, K_OP = 3'd2, K_LP = 3'd3,
                         K_RP = 3'd4, K_END = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n, start, tok_valid, tok_ready;
  logic [2:0]  tok_kind;
  logic [15:0] tok_value;
  logic        q_wr_en;
  logic [5:0]  q_wr_addr;
  logic [16:0] q_wr_data;
  logic [6:0]  output_queue_p;
  logic        busy, done, error;
  logic [1:0]  err_code;

  rpn_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tok_valid(tok_valid),
    .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_value(tok_value),
    .q_wr_en(q_wr_en), .q_wr_addr(q_wr_addr), .q_wr_data(q_wr_data),
    .output_queue_p(output_queue_p), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Write capture, sampled on the falling edge.
  logic [16:0] cap_data [512];
  logic [5:0]  cap_addr [512];
  int          wr_total = 0;
  always @(negedge clk) begin
    if (q_wr_en === 1'b1 && wr_total < 512) begin
      cap_data[wr_total] = q_wr_data;
      cap_addr[wr_total] = q_wr_addr;
      wr_total++;
    end
  end

  typedef struct packed {
    logic [3:0]        ntok;
    logic [9:0][18:0]  toks;
    logic [3:0]        nq;
    logic [9:0][16:0]  q;
    logic              chk_cnt;
    logic              exp_err;
    logic [1:0]        exp_code;
  } vec_t;

  vec_t vecs [10];
  int   nvec = 0;
  int   checks = 0;
  int   failures = 0;
  int   base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic new_vec(input logic err, input logic [1:0] code, input logic chk);
    vecs[nvec] = '0;
    vecs[nvec].exp_err  = err;
    vecs[nvec].exp_code = code;
    vecs[nvec].chk_cnt  = chk;
    nvec++;
  endtask

  task automatic tk(input logic [2:0] k, input logic [15:0] v);
    vecs[nvec-1].toks[vecs[nvec-1].ntok] = {k, v};
    vecs[nvec-1].ntok = vecs[nvec-1].ntok + 4'd1;
  endtask

  task automatic eq(input logic [16:0] d);
    vecs[nvec-1].q[vecs[nvec-1].nq] = d;
    vecs[nvec-1].nq = vecs[nvec-1].nq + 4'd1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 base = wr_total;
  endtask

  task automatic send(input logic [2:0] k, input logic [15:0] v);
    bit ok = 0;
    tok_kind = k;
    tok_value = v;
    tok_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (tok_ready) begin
        @(posedge clk);
        ok = 1;
      end
      @(negedge clk);
    end
    tok_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got tok_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic wait_end(input string name);
    for (int c = 0; c < 200 && !(done || error); c++) @(negedge clk);
    #1 check({name, "_finished"}, {31'd0, done | error}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tok_valid = 1'b0; tok_kind = 3'd0; tok_value = 16'd0;

    // 2+3*x
    new_vec(0, 0, 1);
    tk(K_NUM, 16'h0200); tk(K_OP, 0); tk(K_NUM, 16'h0300); tk(K_OP, 2); tk(K_X, 0); tk(K_END, 0);
    eq(17'h00200); eq(17'h00300); eq(17'h10007); eq(17'h10002); eq(17'h10000);
    // (2+3)*x
    new_vec(0, 0, 1);
    tk(K_LP, 0); tk(K_NUM, 16'h0200); tk(K_OP, 0); tk(K_NUM, 16'h0300); tk(K_RP, 0);
    tk(K_OP, 2); tk(K_X, 0); tk(K_END, 0);
    eq(17'h00200); eq(17'h00300); eq(17'h10000); eq(17'h10007); eq(17'h10002);
    // 2^3^2
    new_vec(0, 0, 1);
    tk(K_NUM, 16'h0200); tk(K_OP, 4); tk(K_NUM, 16'h0300); tk(K_OP, 4); tk(K_NUM, 16'h0200); tk(K_END, 0);
    eq(17'h00200); eq(17'h00300); eq(17'h00200); eq(17'h10004); eq(17'h10004);
    // 2-3-2
    new_vec(0, 0, 1);
    tk(K_NUM, 16'h0200); tk(K_OP, 1); tk(K_NUM, 16'h0300); tk(K_OP, 1); tk(K_NUM, 16'h0200); tk(K_END, 0);
    eq(17'h00200); eq(17'h00300); eq(17'h10001); eq(17'h00200); eq(17'h10001);
    // 2*3+1: higher-precedence operator popped before a lower one
    new_vec(0, 0, 1);
    tk(K_NUM, 16'h0200); tk(K_OP, 2); tk(K_NUM, 16'h0300); tk(K_OP, 0); tk(K_NUM, 16'h0100); tk(K_END, 0);
    eq(17'h00200); eq(17'h00300); eq(17'h10002); eq(17'h00100); eq(17'h10000);
    // 2+3) : unmatched close paren
    new_vec(1, 2'd3, 0);
    tk(K_NUM, 16'h0200); tk(K_OP, 0); tk(K_NUM, 16'h0300); tk(K_RP, 0);
    // 2) : unmatched close paren with empty stack
    new_vec(1, 2'd3, 1);
    tk(K_NUM, 16'h0200); tk(K_RP, 0);
    eq(17'h00200);
    // (2 END : unclosed paren
    new_vec(1, 2'd3, 1);
    tk(K_LP, 0); tk(K_NUM, 16'h0200); tk(K_END, 0);
    eq(17'h00200);
    // 2 then OP code 6
    new_vec(1, 2'd0, 1);
    tk(K_NUM, 16'h0200); tk(K_OP, 16'h0006);
    eq(17'h00200);
    // token kind 7
    new_vec(1, 2'd0, 1);
    tk(3'd7, 16'h0000);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_tok_ready", {31'd0, tok_ready}, 0);
    check("rst_q_wr_en", {31'd0, q_wr_en}, 0);
    check("rst_q_wr_addr", {26'd0, q_wr_addr}, 0);
    check("rst_q_wr_data", {15'd0, q_wr_data}, 0);
    check("rst_output_queue_p", {25'd0, output_queue_p}, 0);
    check("rst_flags", {28'd0, busy, done, error, 1'b0}, 0);
    check("rst_err_code", {30'd0, err_code}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("idle_tok_ready", {31'd0, tok_ready}, 0);

    for (int v = 0; v < nvec; v++) begin
      pulse_start();
      for (int i = 0; i < vecs[v].ntok; i++)
        send(vecs[v].toks[i][18:16], vecs[v].toks[i][15:0]);
      wait_end($sformatf("vec%0d", v));
      check($sformatf("vec%0d_done", v), {31'd0, done}, {31'd0, !vecs[v].exp_err});
      check($sformatf("vec%0d_error", v), {31'd0, error}, {31'd0, vecs[v].exp_err});
      if (vecs[v].exp_err)
        check($sformatf("vec%0d_err_code", v), {30'd0, err_code}, {30'd0, vecs[v].exp_code});
      check($sformatf("vec%0d_ready_low", v), {30'd0, tok_ready, busy}, 0);
      if (vecs[v].chk_cnt) begin
        check($sformatf("vec%0d_queue_p", v), {25'd0, output_queue_p}, {28'd0, vecs[v].nq});
        check($sformatf("vec%0d_writes", v), wr_total - base, {28'd0, vecs[v].nq});
        for (int i = 0; i < vecs[v].nq; i++) begin
          check($sformatf("vec%0d_q%0d", v, i), {15'd0, cap_data[base+i]}, {15'd0, vecs[v].q[i]});
          check($sformatf("vec%0d_addr%0d", v, i), {26'd0, cap_addr[base+i]}, i);
        end
      end
    end

    // 17 open parens overflow the 16-deep op stack
    pulse_start();
    for (int i = 0; i < 17; i++) send(K_LP, 16'd0);
    wait_end("stack_ovf");
    check("stack_ovf_error", {31'd0, error}, 1);
    check("stack_ovf_code", {30'd0, err_code}, 2);

    // 65 numbers overflow the 64-entry queue
    pulse_start();
    for (int i = 0; i < 65; i++) send(K_NUM, 16'(i));
    wait_end("queue_ovf");
    check("queue_ovf_error", {31'd0, error}, 1);
    check("queue_ovf_code", {30'd0, err_code}, 1);
    check("queue_ovf_queue_p", {25'd0, output_queue_p}, 64);
    check("queue_ovf_writes", wr_total - base, 64);
    check("queue_ovf_last_data", {15'd0, cap_data[base+63]}, 32'd63);
    check("queue_ovf_last_addr", {26'd0, cap_addr[base+63]}, 63);

    // Reset during FLUSH of 2+3*4
    pulse_start();
    send(K_NUM, 16'h0200); send(K_OP, 0); send(K_NUM, 16'h0300); send(K_OP, 2);
    send(K_NUM, 16'h0400); send(K_END, 0);
    #1 check("flush_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {22'd0, tok_ready, q_wr_en, busy, done, error, err_code, 3'd0},
          0);
    check("midrst_queue_p", {25'd0, output_queue_p}, 0);
    check("midrst_addr_data", {9'd0, q_wr_addr, q_wr_data}, 0);
    base = wr_total;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("midrst_no_writes", wr_total - base, 0);
    check("midrst_idle", {30'd0, tok_ready, busy}, 0);

    // Restart with "x"
    pulse_start();
    send(K_X, 0); send(K_END, 0);
    wait_end("restart");
    check("restart_done", {31'd0, done}, 1);
    check("restart_queue_p", {25'd0, output_queue_p}, 1);
    check("restart_writes", wr_total - base, 1);
    check("restart_q0", {15'd0, cap_data[base]}, 32'h10007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
